// File: rtl/mc_ctrl_unit_pkg.sv
// Shared control-unit types: FSM states, opcodes and the select-line encodings
// driven toward the multicycle datapath.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] immsrc_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_unit_if.sv
// Instruction fields / flags in, datapath control lines out. slave = control unit.
interface mc_ctrl_unit_if #(parameter int CNT_W = 32);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero, lt, ltu, mem_ready;
  logic             pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0]       resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0]       alucontrol;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport slave (
    input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal, instret
  );
  modport master (
    output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal, instret
  );
endinterface

// File: rtl/mc_ctrl_unit_alu_decoder.sv
// ALU operation select: fixed add/sub from the FSM, or decoded from funct fields.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // opb5 separates R-type from I-type so addi never turns into sub
          3'b000:  alucontrol = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle RV32 control FSM with retired-instruction counter.
// Define CTRL_BRANCH_EXT_EN to add blt/bge/bltu/bgeu to the beq/bne base.
module mc_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  mc_ctrl_unit_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic             taken, br_legal, retire;
  logic [1:0]       resultsrc, alusrca, alusrcb, aluop;

  alu_decoder u_alu_dec (
    .opb5      (bus.op[5]),
    .funct3    (bus.funct3),
    .funct7b5  (bus.funct7b5),
    .aluop     (aluop),
    .alucontrol(bus.alucontrol)
  );

  always_comb begin
    taken    = 1'b0;
    br_legal = 1'b0;
    case (bus.funct3)
      3'b000: begin taken = bus.zero;  br_legal = 1'b1; end
      3'b001: begin taken = ~bus.zero; br_legal = 1'b1; end
`ifdef CTRL_BRANCH_EXT_EN
      3'b100: begin taken = bus.lt;    br_legal = 1'b1; end
      3'b101: begin taken = ~bus.lt;   br_legal = 1'b1; end
      3'b110: begin taken = bus.ltu;   br_legal = 1'b1; end
      3'b111: begin taken = ~bus.ltu;  br_legal = 1'b1; end
`else
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    resultsrc = RES_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RD2;
    aluop     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURES;
        irwrite   = bus.mem_ready;
        pcwrite   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH: begin
            state_d = br_legal ? S_BRANCH : S_FETCH;
            illegal = ~br_legal;
          end
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_SUB;
        pcwrite = taken;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // reset drops any in-flight instruction without counting it
    instret_d = instret_q + CNT_W'(retire);
    if (reset) begin
      state_d   = S_FETCH;
      instret_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    instret_q <= instret_d;
  end

  assign bus.pcwrite   = pcwrite  & ~reset;
  assign bus.adrsrc    = adrsrc   & ~reset;
  assign bus.memwrite  = memwrite & ~reset;
  assign bus.irwrite   = irwrite  & ~reset;
  assign bus.regwrite  = regwrite & ~reset;
  assign bus.illegal   = illegal  & ~reset;
  assign bus.resultsrc = resultsrc;
  assign bus.alusrca   = alusrca;
  assign bus.alusrcb   = alusrcb;
  assign bus.immsrc    = immsrc_of(bus.op);
  assign bus.instret   = instret_q;

endmodule

// File: doc/mc_ctrl_unit.md
MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width passed through to the datapath (no effect on control encoding).
REQ-002 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports op[6:0], funct3[2:0] and funct7b5, all inputs, taken from the instruction register.
REQ-006 SHALL have inputs zero, lt and ltu (1 bit each), which are ALU flags for the current cycle.
REQ-007 SHALL have input mem_ready (1 bit): the memory accepts or returns data in the current cycle.
REQ-008 SHALL have 1-bit outputs pcwrite, adrsrc, memwrite, irwrite and regwrite.
REQ-009 SHALL have 2-bit outputs resultsrc, alusrca, alusrcb and immsrc, plus 3-bit output alucontrol.
REQ-010 SHALL have outputs illegal (1-bit pulse) and instret[CNT_W-1:0] (retired-instruction count).

Function
REQ-011 SHALL use a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH and JAL; the only Mealy terms SHALL be mem_ready gating and the branch result.
REQ-012 SHALL use these encodings: alusrca 00=pc, 01=oldpc, 10=rd1; alusrcb 00=rd2, 01=imm, 10=4; resultsrc 00=aluout, 01=data, 10=aluresult.
REQ-013 SHALL derive immsrc combinationally from op: I=00, S=01 (0100011), B=10 (1100011), J=11 (1101111).
REQ-014 FETCH SHALL drive adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10, and assert irwrite and pcwrite only when mem_ready=1.
REQ-015 FETCH SHALL stay in FETCH while mem_ready=0, and go to DECODE when mem_ready=1.
REQ-016 DECODE SHALL drive alusrca=01, alusrcb=01, add, and select the next state from op.
REQ-017 From DECODE, op 0000011 or 0100011 SHALL go to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 to BRANCH; 1101111 to JAL.
REQ-018 From DECODE, any other op SHALL go to FETCH with illegal=1 for that one cycle.
REQ-019 MEMADR SHALL drive alusrca=10, alusrcb=01, add, then go to MEMREAD if op[5]=0, else to MEMWRITE.
REQ-020 MEMREAD SHALL drive adrsrc=1, hold until mem_ready=1, then go to MEMWB.
REQ-021 MEMWB SHALL drive resultsrc=01 and regwrite=1, then go to FETCH.
REQ-022 MEMWRITE SHALL drive adrsrc=1 and memwrite=1, stay until mem_ready=1, then go to FETCH.
REQ-023 EXECR SHALL drive alusrca=10, alusrcb=00; EXECI SHALL drive alusrca=10, alusrcb=01; both SHALL use funct decode and go to ALUWB.
REQ-024 ALUWB SHALL drive resultsrc=00 and regwrite=1, then go to FETCH.
REQ-025 JAL SHALL drive alusrca=01, alusrcb=10, add, resultsrc=00 and pcwrite=1, then go to ALUWB.
REQ-026 BRANCH SHALL drive alusrca=10, alusrcb=00, sub, resultsrc=00 and pcwrite=taken, then go to FETCH.
REQ-027 alucontrol SHALL be 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-028 Funct decode SHALL give sub only for R-type with funct7b5=1 and funct3=000.
REQ-029 instret SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH, wrap modulo 2^CNT_W, and not increment on an illegal op.
REQ-030 Write enables (pcwrite, irwrite, regwrite, memwrite) SHALL never be asserted in the same cycle as reset=1.

Reset
REQ-031 Reset SHALL set state=FETCH and instret=0 on the next edge; reset mid-instruction SHALL abandon the instruction without incrementing instret.
REQ-032 While reset=1, all 1-bit outputs and illegal SHALL be 0.

Configuration
REQ-033 With CTRL_BRANCH_EXT_EN undefined, BRANCH SHALL support only beq (taken=zero) and bne (taken=~zero); any other branch funct3 SHALL be handled as illegal in DECODE.
REQ-034 With CTRL_BRANCH_EXT_EN defined, BRANCH SHALL also support blt/bge (taken=lt/~lt) and bltu/bgeu (taken=ltu/~ltu); funct3 010/011 SHALL remain illegal.

Structure
REQ-035 Package ctrl_pkg SHALL hold the state enum, opcode constants and the alucontrol/alusrc/resultsrc/immsrc encodings.
REQ-036 The funct decode SHALL be the sub-module alu_decoder (ports opb5, funct3, funct7b5, aluop, alucontrol); the FSM SHALL drive aluop 00=add, 01=sub, 10=funct.

Verification
REQ-037 add x3,x1,x2 with mem_ready=1 SHALL visit FETCH,DECODE,EXECR,ALUWB; regwrite=1 in cycle 4; instret 0->1.
REQ-038 lw with mem_ready low for 3 cycles in MEMREAD SHALL hold MEMREAD with adrsrc=1 for 4 cycles, then MEMWB with resultsrc=01.
REQ-039 beq with zero=1 SHALL give pcwrite=1 in BRANCH; with zero=0, pcwrite=0; in both cases alucontrol=001.
REQ-040 op=1111111 SHALL give illegal=1 in DECODE, a return to FETCH, and no change to instret.
REQ-041 reset=1 asserted during MEMWRITE SHALL give memwrite=0 in that cycle, state=FETCH next, and instret=0.
REQ-042 With CTRL_BRANCH_EXT_EN defined, bltu with ltu=1 SHALL give pcwrite=1; with the macro undefined, the same instruction SHALL raise illegal.
